// File: rtl/rice_residual_sequencer.sv
// rice_residual_sequencer: parses the partitioned-Rice residual section of one
//   FLAC subframe, one stream bit per accepted transfer, and hands each residual
//   (unary quotient, remainder, Rice parameter) to the downstream Rice decoder.
// Latency: oValid rises one cycle after the last bit of a residual is accepted;
//   oDone pulses one cycle after the last residual is accepted.
// Backpressure: iReady low holds EMIT with stable outputs and oBitReady=0;
//   iBitValid low stalls any bit-consuming state with no state change.
// Optional build macro: RICE_ESCAPE_EN enables the escaped (raw) partition path
//   (parameter nibble 15); without it, nibble 15 is a stream error.
// Ports:
//   iClock, iReset_n            clock, async active-low reset
//   iStart, iBlockSize,
//   iPartOrder, iPredOrder      configuration, latched on iStart in IDLE/ERROR
//   iBit, iBitValid, oBitReady  serial stream input, MSB-first
//   oMSB, oLSB, oRiceParam,
//   oValid, iReady              residual output handshake
//   oDone, oError               end-of-subframe pulse, sticky error flag
module rice_residual_sequencer #(
  parameter int MSB_W = 16,
  parameter int LSB_W = 16,
  parameter int BS_W  = 16
) (
  input  logic             iClock,
  input  logic             iReset_n,
  input  logic             iStart,
  input  logic [BS_W-1:0]  iBlockSize,
  input  logic [3:0]       iPartOrder,
  input  logic [5:0]       iPredOrder,
  input  logic             iBit,
  input  logic             iBitValid,
  output logic             oBitReady,
  output logic [MSB_W-1:0] oMSB,
  output logic [LSB_W-1:0] oLSB,
  output logic [3:0]       oRiceParam,
  output logic             oValid,
  input  logic             iReady,
  output logic             oDone,
  output logic             oError
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PARAM,
    S_UNARY,
    S_REM,
    S_EMIT,
    S_DONE,
    S_ERROR
`ifdef RICE_ESCAPE_EN
    ,
    S_ESC_W,
    S_ESC_S
`endif
  } state_t;

`ifdef RICE_ESCAPE_EN
  // Kind of partition currently being emitted.
  localparam logic [1:0] M_RICE = 2'd0;
  localparam logic [1:0] M_ZERO = 2'd1;
  localparam logic [1:0] M_RAW  = 2'd2;
`endif

  state_t           r_state;
  logic [BS_W-1:0]  r_psize;
  logic [15:0]      r_part_left;
  logic [BS_W-1:0]  r_samp_left;
  logic [3:0]       r_param;
  logic [MSB_W-1:0] r_msb;
  logic [LSB_W-1:0] r_lsb;
  logic [4:0]       r_cnt;
  logic [2:0]       r_nib;
  logic             r_valid;
  logic             r_done;
  logic             r_error;
`ifdef RICE_ESCAPE_EN
  logic [3:0]       r_esc_n;
  logic [4:0]       r_esc_w;
  logic [1:0]       r_esc_mode;
`endif

  logic [BS_W-1:0]  w_psize;
  logic [BS_W-1:0]  w_pred;
  logic             w_cfg_bad;
  logic [15:0]      w_part_init;
  logic             w_bit_xfer;
  logic [3:0]       w_nib_full;
  logic [BS_W-1:0]  w_samp_dec;
`ifdef RICE_ESCAPE_EN
  logic [4:0]       w_esc_full;
`endif

  assign w_psize     = iBlockSize >> iPartOrder;
  assign w_pred      = BS_W'(iPredOrder);
  // Partition 0 must hold at least the warm-up samples; an empty partition is
  // only legal for the single-partition case.
  assign w_cfg_bad   = (w_psize < w_pred) || ((w_psize == '0) && (iPartOrder != 4'd0));
  assign w_part_init = (16'd1 << iPartOrder) - 16'd1;
  assign w_bit_xfer  = iBitValid && oBitReady;
  assign w_nib_full  = {r_nib, iBit};
  assign w_samp_dec  = r_samp_left - BS_W'(1);
`ifdef RICE_ESCAPE_EN
  assign w_esc_full  = {r_esc_n, iBit};
`endif

  // Ready is a pure decode of the state register.
  assign oBitReady = (r_state == S_PARAM) || (r_state == S_UNARY) || (r_state == S_REM)
`ifdef RICE_ESCAPE_EN
                     || (r_state == S_ESC_W) || (r_state == S_ESC_S)
`endif
                     ;

  assign oMSB       = r_msb;
  assign oLSB       = r_lsb;
  assign oRiceParam = r_param;
  assign oValid     = r_valid;
  assign oDone      = r_done;
  assign oError     = r_error;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state     <= S_IDLE;
      r_psize     <= '0;
      r_part_left <= '0;
      r_samp_left <= '0;
      r_param     <= '0;
      r_msb       <= '0;
      r_lsb       <= '0;
      r_cnt       <= '0;
      r_nib       <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef RICE_ESCAPE_EN
      r_esc_n     <= '0;
      r_esc_w     <= '0;
      r_esc_mode  <= M_RICE;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (iStart) begin
            r_error <= w_cfg_bad;
            r_psize <= w_psize;
            r_param <= '0;
            r_msb   <= '0;
            r_lsb   <= '0;
            r_cnt   <= '0;
            r_nib   <= '0;
            r_valid <= 1'b0;
`ifdef RICE_ESCAPE_EN
            r_esc_mode <= M_RICE;
`endif
            if (w_cfg_bad) begin
              r_state <= S_ERROR;
            end else begin
              r_part_left <= w_part_init;
              r_samp_left <= w_psize - w_pred;
              r_state     <= S_PARAM;
            end
          end
        end

        S_PARAM: begin
          if (w_bit_xfer) begin
            r_nib <= w_nib_full[2:0];
            if (r_cnt == 5'd3) begin
              r_cnt <= '0;
              if (w_nib_full == 4'hF) begin
`ifdef RICE_ESCAPE_EN
                r_state <= S_ESC_W;
`else
                r_error <= 1'b1;
                r_state <= S_ERROR;
`endif
              end else begin
                r_param <= w_nib_full;
`ifdef RICE_ESCAPE_EN
                r_esc_mode <= M_RICE;
`endif
                if (r_samp_left == '0) begin
                  // Empty partition: straight to the partition-end check.
                  if (r_part_left != '0) begin
                    r_part_left <= r_part_left - 16'd1;
                    r_samp_left <= r_psize;
                    r_state     <= S_PARAM;
                  end else begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                  end
                end else begin
                  r_state <= S_UNARY;
                end
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end

        S_UNARY: begin
          if (w_bit_xfer) begin
            if (!iBit) begin
              if (&r_msb) begin
                // Quotient would not fit in oMSB.
                r_error <= 1'b1;
                r_state <= S_ERROR;
              end else begin
                r_msb <= r_msb + MSB_W'(1);
              end
            end else if (r_param != 4'd0) begin
              r_cnt   <= {1'b0, r_param};
              r_state <= S_REM;
            end else begin
              r_lsb   <= '0;
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end
          end
        end

        S_REM: begin
          if (w_bit_xfer) begin
            r_lsb <= {r_lsb[LSB_W-2:0], iBit};
            if (r_cnt == 5'd1) begin
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end

        S_EMIT: begin
          if (iReady) begin
            r_msb       <= '0;
            r_lsb       <= '0;
            r_samp_left <= w_samp_dec;
            if (w_samp_dec == '0) begin
              r_valid <= 1'b0;
              if (r_part_left != '0) begin
                r_part_left <= r_part_left - 16'd1;
                r_samp_left <= r_psize;
                r_cnt       <= '0;
                r_state     <= S_PARAM;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
`ifdef RICE_ESCAPE_EN
              if (r_esc_mode == M_ZERO) begin
                // All-zero partition: keep emitting without consuming bits.
                r_state <= S_EMIT;
              end else if (r_esc_mode == M_RAW) begin
                r_valid <= 1'b0;
                r_cnt   <= r_esc_w;
                r_state <= S_ESC_S;
              end else begin
                r_valid <= 1'b0;
                r_state <= S_UNARY;
              end
`else
              r_valid <= 1'b0;
              r_state <= S_UNARY;
`endif
            end
          end
        end

`ifdef RICE_ESCAPE_EN
        S_ESC_W: begin
          if (w_bit_xfer) begin
            r_esc_n <= w_esc_full[3:0];
            if (r_cnt == 5'd4) begin
              r_cnt   <= '0;
              r_esc_w <= w_esc_full;
              r_msb   <= '0;
              r_lsb   <= '0;
              if (w_esc_full == 5'd0) begin
                r_param    <= 4'd0;
                r_esc_mode <= M_ZERO;
              end else begin
                r_param    <= 4'hF;
                r_esc_mode <= M_RAW;
              end
              if (r_samp_left == '0) begin
                if (r_part_left != '0) begin
                  r_part_left <= r_part_left - 16'd1;
                  r_samp_left <= r_psize;
                  r_state     <= S_PARAM;
                end else begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end
              end else if (w_esc_full == 5'd0) begin
                r_valid <= 1'b1;
                r_state <= S_EMIT;
              end else begin
                r_cnt   <= w_esc_full;
                r_state <= S_ESC_S;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end

        S_ESC_S: begin
          if (w_bit_xfer) begin
            r_lsb <= {r_lsb[LSB_W-2:0], iBit};
            if (r_cnt == 5'd1) begin
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
`endif

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rice_residual_sequencer.sv
// tb_rice_residual_sequencer: drives bit streams into rice_residual_sequencer
//   and compares every emitted residual against expectations queued when the
//   stream was built; also checks reset, error, stall and timing behaviour.
module tb_rice_residual_sequencer;

  localparam int MSB_W = 16;
  localparam int LSB_W = 16;
  localparam int BS_W  = 16;

  logic             iClock = 1'b0;
  logic             iReset_n = 1'b0;
  logic             iStart = 1'b0;
  logic [BS_W-1:0]  iBlockSize = '0;
  logic [3:0]       iPartOrder = '0;
  logic [5:0]       iPredOrder = '0;
  logic             iBit = 1'b0;
  logic             iBitValid = 1'b0;
  logic             oBitReady;
  logic [MSB_W-1:0] oMSB;
  logic [LSB_W-1:0] oLSB;
  logic [3:0]       oRiceParam;
  logic             oValid;
  logic             iReady = 1'b1;
  logic             oDone;
  logic             oError;

  typedef struct packed {
    logic [MSB_W-1:0] msb;
    logic [LSB_W-1:0] lsb;
    logic [3:0]       param;
  } res_t;

  res_t sb[$];
  bit   bq[$];
  int   checks = 0;
  int   errors = 0;

  rice_residual_sequencer #(.MSB_W(MSB_W), .LSB_W(LSB_W), .BS_W(BS_W)) dut (
    .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart),
    .iBlockSize(iBlockSize), .iPartOrder(iPartOrder), .iPredOrder(iPredOrder),
    .iBit(iBit), .iBitValid(iBitValid), .oBitReady(oBitReady),
    .oMSB(oMSB), .oLSB(oLSB), .oRiceParam(oRiceParam), .oValid(oValid),
    .iReady(iReady), .oDone(oDone), .oError(oError)
  );

  always #5 iClock = ~iClock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h31) bq.push_back(1'b1);
      else if (s[i] == 8'h30) bq.push_back(1'b0);
    end
  endtask

  task automatic push_val(input int v, input int w);
    for (int k = w - 1; k >= 0; k--) bq.push_back(v[k]);
  endtask

  task automatic push_res(input int m, input int l, input int p);
    res_t r;
    r.msb = MSB_W'(m);
    r.lsb = LSB_W'(l);
    r.param = 4'(p);
    sb.push_back(r);
  endtask

  // One partition with a random parameter and n random residuals.
  task automatic gen_part(input int n);
    int p, m, l;
    p = $urandom_range(0, 14);
    push_val(p, 4);
    for (int i = 0; i < n; i++) begin
      m = $urandom_range(0, 5);
      l = (p == 0) ? 0 : $urandom_range(0, (1 << p) - 1);
      for (int k = 0; k < m; k++) bq.push_back(1'b0);
      bq.push_back(1'b1);
      push_val(l, p);
      push_res(m, l, p);
    end
  endtask

  task automatic start(input int bs, input int po, input int pr);
    @(negedge iClock);
    iBlockSize = BS_W'(bs);
    iPartOrder = 4'(po);
    iPredOrder = 6'(pr);
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
  endtask

  // Feed n queued bits one per cycle, expecting the DUT ready on each.
  task automatic feed(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      iBitValid = 1'b1;
      iBit = bq.pop_front();
      checks++;
      if (oBitReady !== 1'b1) begin
        errors++;
        $display("FAIL %s feed: oBitReady=%b at bit %0d, expected 1", name, oBitReady, i);
      end
      @(negedge iClock);
    end
    iBitValid = 1'b0;
    iBit = 1'b0;
  endtask

  // Streams bq into the DUT and scores residuals until oDone or timeout.
  task automatic run(input string name, input int hold, input bit stall);
    int cyc, consumed, nbits, last_bit, last_acc, done_cyc, hold_left;
    bit first_valid;
    res_t e;
    cyc = 0; consumed = 0; nbits = bq.size();
    last_bit = -10; last_acc = -10; done_cyc = -1;
    hold_left = hold; first_valid = 1'b1;
    while (cyc < 3000) begin
      if (oDone) begin
        done_cyc = cyc;
        break;
      end
      if (oError) begin
        checks++; errors++;
        $display("FAIL %s: oError=1 at cycle %0d, expected 0", name, cyc);
        break;
      end
      iReady = 1'b1;
      if (oValid) begin
        if (first_valid) begin
          first_valid = 1'b0;
          checks++;
          if (cyc != last_bit + 1) begin
            errors++;
            $display("FAIL %s latency: oValid at cycle %0d, expected %0d", name, cyc, last_bit + 1);
          end
        end
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s: unexpected residual msb=%0d lsb=%0h", name, oMSB, oLSB);
          break;
        end
        e = sb[0];
        if (hold_left > 0) begin
          hold_left--;
          iReady = 1'b0;
          checks++;
          if (oMSB !== e.msb || oLSB !== e.lsb || oRiceParam !== e.param || oBitReady !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: msb=%0d lsb=%0h param=%0d rdy=%b, expected msb=%0d lsb=%0h param=%0d rdy=0",
                     name, oMSB, oLSB, oRiceParam, oBitReady, e.msb, e.lsb, e.param);
          end
        end else if (stall && $urandom_range(0, 2) == 0) begin
          iReady = 1'b0;
        end else begin
          void'(sb.pop_front());
          checks++;
          if (oMSB !== e.msb || oLSB !== e.lsb || oRiceParam !== e.param) begin
            errors++;
            $display("FAIL %s residual: got msb=%0d lsb=%0h param=%0d, expected msb=%0d lsb=%0h param=%0d",
                     name, oMSB, oLSB, oRiceParam, e.msb, e.lsb, e.param);
          end
          last_acc = cyc;
        end
      end
      if (bq.size() > 0 && (!stall || $urandom_range(0, 3) != 0)) begin
        iBitValid = 1'b1;
        iBit = bq[0];
      end else begin
        iBitValid = 1'b0;
        iBit = 1'b0;
      end
      if (iBitValid && oBitReady) begin
        void'(bq.pop_front());
        consumed++;
        last_bit = cyc;
      end
      @(negedge iClock);
      cyc++;
    end
    iBitValid = 1'b0;
    iBit = 1'b0;
    iReady = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s done: oDone never seen, expected a pulse", name);
    end else begin
      checks++;
      if (done_cyc != last_acc + 1) begin
        errors++;
        $display("FAIL %s done timing: oDone at cycle %0d, expected %0d", name, done_cyc, last_acc + 1);
      end
      @(negedge iClock);
      checks++;
      if (oDone !== 1'b0 || oBitReady !== 1'b0 || oValid !== 1'b0) begin
        errors++;
        $display("FAIL %s after done: oDone=%b rdy=%b valid=%b, expected 0 0 0", name, oDone, oBitReady, oValid);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d residuals missing, expected 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (consumed != nbits || bq.size() != 0) begin
      errors++;
      $display("FAIL %s bits: consumed %0d, expected %0d", name, consumed, nbits);
      bq.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (oBitReady !== 1'b0 || oMSB !== '0 || oLSB !== '0 || oRiceParam !== 4'd0 ||
        oValid !== 1'b0 || oDone !== 1'b0 || oError !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b msb=%0d lsb=%0h param=%0d valid=%b done=%b err=%b, expected all 0",
               oBitReady, oMSB, oLSB, oRiceParam, oValid, oDone, oError);
    end
    @(negedge iClock);
    iReset_n = 1'b1;
    @(negedge iClock);
    checks++;
    if (oBitReady !== 1'b0 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL idle: rdy=%b valid=%b, expected 0 0", oBitReady, oValid);
    end
  endtask

  task automatic test_basic();
    start(4, 0, 2);
    push_bits("0010 00111 100");
    push_res(2, 3, 2);
    push_res(0, 0, 2);
    checks++;
    if (bq.size() != 12) begin
      errors++;
      $display("FAIL basic stream length: %0d, expected 12", bq.size());
    end
    run("basic", 0, 1'b0);
  endtask

  task automatic test_partitions();
    start(4, 1, 1);
    push_bits("0000 001 0011 01101 1010");
    push_res(2, 0, 0);
    push_res(1, 5, 3);
    push_res(0, 2, 3);
    run("partitions", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    start(4, 0, 2);
    push_bits("0001 011 00010");
    push_res(1, 1, 1);
    push_res(3, 0, 1);
    run("backpressure", 5, 1'b0);
  endtask

  task automatic test_stall();
    start(8, 1, 0);
    gen_part(4);
    gen_part(4);
    run("stall", 0, 1'b1);
  endtask

  task automatic test_error_cfg();
    start(4, 2, 2);
    iBitValid = 1'b1;
    iBit = 1'b1;
    checks++;
    if (oError !== 1'b1 || oBitReady !== 1'b0 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL cfg psize<pred: err=%b rdy=%b valid=%b, expected 1 0 0", oError, oBitReady, oValid);
    end
    @(negedge iClock);
    iBitValid = 1'b0;
    start(2, 2, 0);
    checks++;
    if (oError !== 1'b1 || oBitReady !== 1'b0) begin
      errors++;
      $display("FAIL cfg empty partition: err=%b rdy=%b, expected 1 0", oError, oBitReady);
    end
    start(2, 0, 0);
    checks++;
    if (oError !== 1'b0 || oBitReady !== 1'b1) begin
      errors++;
      $display("FAIL cfg recover: err=%b rdy=%b, expected 0 1", oError, oBitReady);
    end
    push_bits("0000 1 01");
    push_res(0, 0, 0);
    push_res(1, 0, 0);
    run("recover", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    start(4, 0, 0);
    push_bits("0011 1 1");
    feed("midreset", 6);
    checks++;
    if (oLSB !== 16'd1 || oRiceParam !== 4'd3 || oBitReady !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre: lsb=%0h param=%0d rdy=%b, expected 1 3 1", oLSB, oRiceParam, oBitReady);
    end
    iReset_n = 1'b0;
    #1;
    checks++;
    if (oBitReady !== 1'b0 || oMSB !== '0 || oLSB !== '0 || oRiceParam !== 4'd0 ||
        oValid !== 1'b0 || oDone !== 1'b0 || oError !== 1'b0) begin
      errors++;
      $display("FAIL midreset: rdy=%b msb=%0d lsb=%0h param=%0d valid=%b done=%b err=%b, expected all 0",
               oBitReady, oMSB, oLSB, oRiceParam, oValid, oDone, oError);
    end
    @(negedge iClock);
    iReset_n = 1'b1;
    start(2, 0, 0);
    push_bits("0010 111 0100");
    push_res(0, 3, 2);
    push_res(1, 0, 2);
    run("after reset", 0, 1'b0);
  endtask

  task automatic test_escape();
    start(2, 0, 0);
`ifdef RICE_ESCAPE_EN
    push_bits("1111 00100 1010 0110");
    push_res(0, 10, 15);
    push_res(0, 6, 15);
    run("escape raw", 0, 1'b0);
    start(3, 0, 0);
    push_bits("1111 00000");
    push_res(0, 0, 0);
    push_res(0, 0, 0);
    push_res(0, 0, 0);
    run("escape zero", 0, 1'b0);
`else
    push_bits("1111");
    feed("escape off", 4);
    checks++;
    if (oError !== 1'b1 || oBitReady !== 1'b0 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL escape off: err=%b rdy=%b valid=%b, expected 1 0 0", oError, oBitReady, oValid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partitions();
    test_backpressure();
    test_stall();
    test_error_cfg();
    test_reset_mid();
    test_escape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
